// File: rtl/ifp_multi.sv
// ifp_multi: instruction-fetch stage with up to MAX_OUTSTANDING in-order I-mem
// requests in flight, a FIFO_DEPTH-entry {pc, instr} queue to the decoder, and
// redirect handling that discards every response issued before the redirect.
module ifp_multi #(
    parameter logic [63:0] RESET_VECTOR    = 64'h0000_0000_1000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] im_req_addr,
    output logic        im_req_valid,
    input  logic        im_req_ready,
    input  logic [63:0] im_resp_rdata,
    input  logic        im_resp_valid,
    output logic [63:0] if_dec_pc,
    output logic [31:0] if_dec_instr,
    output logic        if_dec_valid,
    input  logic        if_dec_ready,
    input  logic        ip_if_pc_override,
    input  logic [63:0] ip_if_new_pc
);

    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW  = $clog2(FIFO_DEPTH + 1);
    localparam int CW  = $clog2(MAX_OUTSTANDING + FIFO_DEPTH + 1);
    localparam int TPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int FPW = $clog2(FIFO_DEPTH);

    logic [63:0]    fetch_pc;

    logic [63:0]    tag_q [MAX_OUTSTANDING];
    logic [TPW-1:0] tag_wr;
    logic [TPW-1:0] tag_rd;

    logic [OW-1:0]  outstanding;
    logic [OW-1:0]  drop_cnt;

    logic [63:0]    fifo_pc    [FIFO_DEPTH];
    logic [31:0]    fifo_instr [FIFO_DEPTH];
    logic [FPW-1:0] fifo_wr;
    logic [FPW-1:0] fifo_rd;
    logic [FW-1:0]  fifo_count;

    logic [CW-1:0]  live_credit;
    logic           req_fire;
    logic           resp_ok;
    logic           resp_drop;
    logic           resp_live;
    logic           fifo_pop;
    logic [63:0]    tag_head;
    logic [31:0]    resp_instr;

    // Tag pointers wrap explicitly so a single-entry tag queue stays in range.
    function automatic logic [TPW-1:0] tag_next(input logic [TPW-1:0] ptr);
        return (ptr == TPW'(MAX_OUTSTANDING - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Request credit, response classification and head-of-queue selection.
    always_comb begin
        // drop_cnt never exceeds outstanding, so the subtraction cannot wrap.
        live_credit  = CW'(outstanding) - CW'(drop_cnt) + CW'(fifo_count);
        im_req_valid = !rst && !ip_if_pc_override
                       && (outstanding < OW'(MAX_OUTSTANDING))
                       && (live_credit < CW'(FIFO_DEPTH));
        im_req_addr  = fetch_pc;
        req_fire     = im_req_valid && im_req_ready;

        // A response with nothing outstanding is a protocol violation: ignore it.
        resp_ok      = im_resp_valid && (outstanding != '0);
        resp_drop    = resp_ok && ((drop_cnt != '0) || ip_if_pc_override);
        resp_live    = resp_ok && (drop_cnt == '0) && !ip_if_pc_override;

        tag_head     = tag_q[tag_rd];
        resp_instr   = tag_head[2] ? im_resp_rdata[63:32] : im_resp_rdata[31:0];

        if_dec_valid = (fifo_count != '0) && !ip_if_pc_override;
        if_dec_pc    = fifo_pc[fifo_rd];
        if_dec_instr = fifo_instr[fifo_rd];
        fifo_pop     = if_dec_valid && if_dec_ready;
    end

    // Fetch PC: redirect target wins, otherwise advance one word per fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_VECTOR;
        end else if (ip_if_pc_override) begin
            fetch_pc <= ip_if_new_pc;
        end else if (req_fire) begin
            fetch_pc <= fetch_pc + 64'd4;
        end
    end

    // In-flight bookkeeping; on redirect every still-pending response becomes a drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (ip_if_pc_override) begin
            outstanding <= outstanding - OW'(resp_ok);
            drop_cnt    <= outstanding - OW'(resp_ok);
        end else begin
            outstanding <= outstanding + OW'(req_fire) - OW'(resp_ok);
            if (resp_drop) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    // Tag queue pointers; cleared on redirect since dropped responses never pop.
    always_ff @(posedge clk) begin
        if (rst || ip_if_pc_override) begin
            tag_wr <= '0;
            tag_rd <= '0;
        end else begin
            if (req_fire) begin
                tag_wr <= tag_next(tag_wr);
            end
            if (resp_live) begin
                tag_rd <= tag_next(tag_rd);
            end
        end
    end

    // Tag queue storage: PC of each issued request.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_q[tag_wr] <= fetch_pc;
        end
    end

    // Output FIFO pointers and occupancy; flushed on redirect.
    always_ff @(posedge clk) begin
        if (rst || ip_if_pc_override) begin
            fifo_wr    <= '0;
            fifo_rd    <= '0;
            fifo_count <= '0;
        end else begin
            if (resp_live) begin
                fifo_wr <= fifo_wr + 1'b1;
            end
            if (fifo_pop) begin
                fifo_rd <= fifo_rd + 1'b1;
            end
            fifo_count <= fifo_count + FW'(resp_live) - FW'(fifo_pop);
        end
    end

    // Output FIFO storage: selected instruction with its PC.
    always_ff @(posedge clk) begin
        if (resp_live) begin
            fifo_pc[fifo_wr]    <= tag_head;
            fifo_instr[fifo_wr] <= resp_instr;
        end
    end

endmodule

// File: tb/tb_ifp_multi.sv
// Directed bench for ifp_multi: in-order memory model with settable latency,
// decoder scoreboard on expected PC stream, and targeted redirect/stall cases.
module tb_ifp_multi;

    localparam logic [63:0] RV = 64'h0000_0000_1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] im_req_addr;
    logic        im_req_valid;
    logic        im_req_ready;
    logic [63:0] im_resp_rdata = '0;
    logic        im_resp_valid = 1'b0;
    logic [63:0] if_dec_pc;
    logic [31:0] if_dec_instr;
    logic        if_dec_valid;
    logic        if_dec_ready;
    logic        ip_if_pc_override;
    logic [63:0] ip_if_new_pc;

    int n_chk = 0;
    int n_err = 0;
    int n_pop = 0;
    int cyc   = 0;
    int lat   = 1;
    logic [63:0] exp_pc;
    logic [63:0] exp_req_addr;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    ifp_multi #(
        .RESET_VECTOR   (RV),
        .FIFO_DEPTH     (4),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .im_req_addr      (im_req_addr),
        .im_req_valid     (im_req_valid),
        .im_req_ready     (im_req_ready),
        .im_resp_rdata    (im_resp_rdata),
        .im_resp_valid    (im_resp_valid),
        .if_dec_pc        (if_dec_pc),
        .if_dec_instr     (if_dec_instr),
        .if_dec_valid     (if_dec_valid),
        .if_dec_ready     (if_dec_ready),
        .ip_if_pc_override(ip_if_pc_override),
        .ip_if_new_pc     (ip_if_new_pc)
    );

    always #5 clk = ~clk;

    // Instruction word stored at a given PC; adjacent words always differ.
    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'hDEAD_0000;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory response driver: head of queue returns once its due cycle is reached.
    always @(posedge clk) begin
        logic [63:0] d;
        cyc++;
        #1;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            d             = mq[0].addr & ~64'd7;
            im_resp_valid = 1'b1;
            im_resp_rdata = {instr_of(d + 64'd4), instr_of(d)};
        end else begin
            im_resp_valid = 1'b0;
            im_resp_rdata = '0;
        end
    end

    // Mid-cycle sampling: request acceptance, response consumption, decoder scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
        end else begin
            if (im_resp_valid && mq.size() > 0) begin
                void'(mq.pop_front());
            end
            if (im_req_valid && im_req_ready) begin
                check_val("req_addr", im_req_addr, exp_req_addr);
                exp_req_addr = exp_req_addr + 64'd4;
                mq.push_back('{addr: im_req_addr, due: cyc + lat});
            end
            if (if_dec_valid && if_dec_ready) begin
                check_val("dec_pc", if_dec_pc, exp_pc);
                check_val("dec_instr", {32'd0, if_dec_instr}, {32'd0, instr_of(exp_pc)});
                exp_pc = exp_pc + 64'd4;
                n_pop++;
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic redirect(input logic [63:0] target);
        ip_if_pc_override = 1'b1;
        ip_if_new_pc      = target;
        exp_pc            = target;
        exp_req_addr      = target;
    endtask

    task automatic wait_dec(input string tag, input logic [63:0] first_pc);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (if_dec_valid) begin
                seen = 1'b1;
                check_val(tag, if_dec_pc, first_pc);
            end
        end
        if (!seen) check_val({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0;
        int max_out;
        bit hit;

        rst               = 1'b1;
        im_req_ready      = 1'b1;
        if_dec_ready      = 1'b1;
        ip_if_pc_override = 1'b0;
        ip_if_new_pc      = '0;
        exp_pc            = RV;
        exp_req_addr      = RV;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_req_valid", im_req_valid, 0);
        check_val("rst_dec_valid", if_dec_valid, 0);
        check_val("rst_req_addr", im_req_addr, RV);
        check_val("rst_outstanding", dut.outstanding, 0);

        // First request right after reset, 1-cycle memory
        drive_edge();
        rst = 1'b0;
        @(negedge clk);
        check_val("first_req_valid", im_req_valid, 1);
        check_val("first_req_addr", im_req_addr, RV);
        @(negedge clk);
        check_val("lat_c1_dec_valid", if_dec_valid, 0);
        check_val("lat_c1_resp_valid", im_resp_valid, 1);
        @(negedge clk);
        check_val("lat_c2_dec_valid", if_dec_valid, 1);
        check_val("lat_c2_dec_pc", if_dec_pc, RV);
        p0 = n_pop;
        repeat (10) @(negedge clk);
        check_val("throughput_10", n_pop - p0, 10);

        // Decoder stall fills the queue and throttles requests
        drive_edge();
        if_dec_ready = 1'b0;
        repeat (10) @(negedge clk);
        check_val("stall_req_valid", im_req_valid, 0);
        check_val("stall_dec_valid", if_dec_valid, 1);
        check_val("stall_fifo_count", dut.fifo_count, 4);
        check_val("stall_outstanding", dut.outstanding, 0);
        drive_edge();
        if_dec_ready = 1'b1;
        repeat (10) @(negedge clk);

        // 3-cycle memory: never more than 2 in flight
        drive_edge();
        lat = 3;
        max_out = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (int'(dut.outstanding) > max_out) max_out = int'(dut.outstanding);
            if (dut.outstanding == 2) check_val("max_out_req_valid", im_req_valid, 0);
        end
        check_val("max_outstanding", max_out, 2);

        // Redirect with 2 requests in flight
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            drive_edge();
            if (dut.outstanding == 2) hit = 1'b1;
        end
        if (!hit) check_val("redir2_setup_timeout", 64'd0, 64'd1);
        redirect(64'h0000_0000_8000_0000);
        @(negedge clk);
        check_val("redir2_R_dec_valid", if_dec_valid, 0);
        check_val("redir2_R_req_valid", im_req_valid, 0);
        drive_edge();
        ip_if_pc_override = 1'b0;
        @(negedge clk);
        check_val("redir2_R1_fifo_count", dut.fifo_count, 0);
        check_val("redir2_R1_dec_valid", if_dec_valid, 0);
        wait_dec("redir2_first_pc", 64'h0000_0000_8000_0000);
        repeat (10) @(negedge clk);

        // Redirect coincident with a response while one request is outstanding
        drive_edge();
        lat = 1;
        repeat (10) @(negedge clk);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            drive_edge();
            if (dut.outstanding == 1 && im_resp_valid) hit = 1'b1;
        end
        if (!hit) check_val("redir1_setup_timeout", 64'd0, 64'd1);
        redirect(64'h0000_0000_9000_0000);
        drive_edge();
        ip_if_pc_override = 1'b0;
        @(negedge clk);
        check_val("redir1_drop_cnt", dut.drop_cnt, 0);
        check_val("redir1_outstanding", dut.outstanding, 0);
        check_val("redir1_dec_valid", if_dec_valid, 0);
        wait_dec("redir1_first_pc", 64'h0000_0000_9000_0000);
        repeat (10) @(negedge clk);

        // Memory back-pressure: address holds until the request fires
        drive_edge();
        im_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("hold_req_addr", im_req_addr, exp_req_addr);
        end
        check_val("hold_req_valid", im_req_valid, 1);
        drive_edge();
        im_req_ready = 1'b1;
        repeat (10) @(negedge clk);

        // Mid-run reset
        drive_edge();
        rst          = 1'b1;
        exp_pc       = RV;
        exp_req_addr = RV;
        drive_edge();
        rst = 1'b0;
        @(negedge clk);
        check_val("rerst_req_addr", im_req_addr, RV);
        check_val("rerst_dec_valid", if_dec_valid, 0);
        check_val("rerst_outstanding", dut.outstanding, 0);
        wait_dec("rerst_first_pc", RV);
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
